des_engine_scheduler: RTL and testbench
=======================================

# des_engine_scheduler

Round-robin scheduler that shares one DES engine among `NUM_REQ` requesters. It accepts a plaintext block and key from one requester at a time, issues a start strobe to the engine, and waits for the engine's `done_strobe`. It then returns the ciphertext on a shared response channel tagged with the requester ID. A watchdog aborts jobs the engine never completes. The block sits between the processing-element input logic and `des_engine`.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: width of the requester ID; must satisfy 2^`ID_W` >= `NUM_REQ`.
- `TIMEOUT`, 32: engine watchdog limit in cycles (>= 2).

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid_din`  in  `NUM_REQ`  per-requester request valid.
- `req_plaintext_din`  in  `NUM_REQ`*64  requester i at bits [64i : 64i+63]; MSB-first [0:63] ordering per block.
- `req_key_din`  in  `NUM_REQ`*64  key per requester, same packing.
- `req_ready_dout`  out  `NUM_REQ`  one-hot grant; a transfer happens on valid&ready.
- `start_strobe_dout`  out  1  one-cycle engine start pulse.
- `plaintext_dout`  out  [0:63]  engine plaintext; held stable from the start pulse until the job ends.
- `key_dout`  out  [0:63]  engine key; same hold rule.
- `done_strobe_din`  in  1  engine completion pulse.
- `ciphertext_din`  in  [0:63]  engine result; valid in the done cycle.
- `resp_valid_dout`  out  1  response valid.
- `resp_ready_din`  in  1  response consumer ready.
- `resp_id_dout`  out  `ID_W`  requester index of the response.
- `resp_ciphertext_dout`  out  [0:63]  result; all zeros on error.
- `resp_error_dout`  out  1  watchdog expired for this job.
- `busy_dout`  out  1  high in any state other than IDLE.
- `jobs_done_dout`  out  16  count of delivered responses, including errors; wraps modulo 2^16.

## Operation

- States:
  - IDLE: grant one requester.
  - ISSUE: pulse the engine start.
  - WAIT: wait for `done_strobe_din` or the watchdog.
  - DELIVER: hold the response until it is accepted.
- IDLE:
  - Search `req_valid_din` starting at `rr_ptr` and wrapping modulo `NUM_REQ`; the first set bit is granted.
  - `req_ready_dout` is combinational: one-hot on the granted index, zero when no request is pending.
  - On the transfer edge: latch plaintext, key and ID; set `rr_ptr` = (grant+1) mod `NUM_REQ`; go to ISSUE.
- ISSUE:
  - `start_strobe_dout`=1 for exactly this cycle.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - On `done_strobe_din`=1: latch `ciphertext_din`, clear the error flag, go to DELIVER.
  - Otherwise, when the counter equals `TIMEOUT`-1: load ciphertext 0x0000000000000000, set the error flag, go to DELIVER.
  - Otherwise: increment the counter.
  - If done and timeout occur in the same cycle, done wins.
- DELIVER:
  - `resp_valid_dout`=1; ID, ciphertext and error held stable.
  - On `resp_ready_din`=1: increment `jobs_done_dout` and go to IDLE.
- `req_ready_dout` is 0 in every state except IDLE.
- A `done_strobe_din` seen outside WAIT is ignored, as is a late done after a timeout.
- Engine outputs `plaintext_dout`/`key_dout` come from the latched registers and keep their last value after a job ends.

## Timing

- Reset values:
  - state IDLE, `rr_ptr`=0, counter 0.
  - Outputs: `start_strobe_dout`=0, `plaintext_dout`=0, `key_dout`=0, `resp_valid_dout`=0, `resp_id_dout`=0, `resp_ciphertext_dout`=0, `resp_error_dout`=0, `busy_dout`=0, `jobs_done_dout`=0.
  - `req_ready_dout` is 0 while `reset` is high.
- Cycle numbering, with the transfer edge at the end of cycle 0:
  - cycle 1: `start_strobe_dout`=1.
  - cycle 2 onward: WAIT.
  - done in cycle k puts `resp_valid_dout`=1 from cycle k+1.
  - An immediate `resp_ready_din` returns to IDLE in cycle k+2, so the next grant can occur in cycle k+2.
- Watchdog: with no done, WAIT lasts exactly `TIMEOUT` cycles (cycles 2 .. `TIMEOUT`+1), and `resp_error_dout`=1 from cycle `TIMEOUT`+2.
- Reset asserted mid-job: the job is abandoned, no response is produced, and all state returns to reset values on the next edge.
- Requests that drop valid before the grant edge are not transferred; no queueing.

## Test plan

- Single request:
  - Stimulus: requester 2 sends plaintext 0x0123456789ABCDEF, key 0x133457799BBCDFF1; engine returns done with 0x85E813540F0AB405 after 16 cycles.
  - Required: one start pulse; response id=2, that ciphertext, error=0; `jobs_done_dout`=1.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously from reset.
  - Required: grant order 0,1,2,3,0; each ID appears once per four responses.
- Watchdog:
  - Stimulus: engine never asserts done, `TIMEOUT`=32.
  - Required: `resp_error_dout`=1 and ciphertext 0 exactly 34 cycles after the transfer edge; a later done strobe is ignored.
- Back-pressure:
  - Stimulus: hold `resp_ready_din`=0 for 10 cycles in DELIVER, pulse a spurious done, and keep requester 1 valid.
  - Required: response fields are stable; `req_ready_dout` stays 0; no second start pulse.
- Reset mid-WAIT:
  - Stimulus: assert `reset` 5 cycles after the start pulse.
  - Required: all outputs at reset values the next cycle, `rr_ptr`=0, no response emitted.
- Done/timeout collision:
  - Stimulus: done arrives in the same cycle the counter hits `TIMEOUT`-1.
  - Required: error=0 and the engine ciphertext is delivered.

Source files
------------

// File: rtl/des_engine_scheduler_if.sv
// Bus bundle between the requesters, the DES engine and the response consumer.
// master: the scheduler side (drives grants, engine controls and responses).
// slave:  the environment side (requesters, engine and response consumer).
// Signals:
//   req_valid_din / req_ready_dout          per-requester valid / one-hot grant
//   req_plaintext_din / req_key_din         NUM_REQ x 64-bit, requester i at [64i : 64i+63]
//   start_strobe_dout, plaintext_dout,
//   key_dout                                engine start pulse and operands
//   done_strobe_din, ciphertext_din         engine completion pulse and result
//   resp_valid_dout / resp_ready_din        response handshake
//   resp_id_dout, resp_ciphertext_dout,
//   resp_error_dout                         response payload
//   busy_dout, jobs_done_dout               status
interface des_engine_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    localparam int unsigned BLK_W  = 64;
    localparam int unsigned JOBS_W = 16;

    logic [NUM_REQ-1:0]         req_valid_din;
    logic [0:NUM_REQ*BLK_W-1]   req_plaintext_din;
    logic [0:NUM_REQ*BLK_W-1]   req_key_din;
    logic [NUM_REQ-1:0]         req_ready_dout;
    logic                       start_strobe_dout;
    logic [0:BLK_W-1]           plaintext_dout;
    logic [0:BLK_W-1]           key_dout;
    logic                       done_strobe_din;
    logic [0:BLK_W-1]           ciphertext_din;
    logic                       resp_valid_dout;
    logic                       resp_ready_din;
    logic [ID_W-1:0]            resp_id_dout;
    logic [0:BLK_W-1]           resp_ciphertext_dout;
    logic                       resp_error_dout;
    logic                       busy_dout;
    logic [JOBS_W-1:0]          jobs_done_dout;

    modport master (
        input  req_valid_din, req_plaintext_din, req_key_din,
        output req_ready_dout,
        output start_strobe_dout, plaintext_dout, key_dout,
        input  done_strobe_din, ciphertext_din,
        output resp_valid_dout,
        input  resp_ready_din,
        output resp_id_dout, resp_ciphertext_dout, resp_error_dout,
        output busy_dout, jobs_done_dout
    );

    modport slave (
        output req_valid_din, req_plaintext_din, req_key_din,
        input  req_ready_dout,
        input  start_strobe_dout, plaintext_dout, key_dout,
        output done_strobe_din, ciphertext_din,
        input  resp_valid_dout,
        output resp_ready_din,
        input  resp_id_dout, resp_ciphertext_dout, resp_error_dout,
        input  busy_dout, jobs_done_dout
    );
endinterface

// File: rtl/des_engine_scheduler.sv
// Round-robin scheduler sharing one DES engine among NUM_REQ requesters.
// Grants one requester, pulses the engine start, waits for done (or the
// watchdog), then returns the tagged ciphertext on the response channel.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    des_engine_scheduler_if.master (requests, engine, response, status)
module des_engine_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    des_engine_scheduler_if.master bus
);
    localparam int unsigned BLK_W  = 64;
    localparam int unsigned JOBS_W = 16;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [ID_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [0:BLK_W-1]    pt_q;
    logic [0:BLK_W-1]    key_q;
    logic [ID_W-1:0]     id_q;
    logic [0:BLK_W-1]    ct_q;
    logic                err_q;
    logic                start_q;
    logic                busy_q;
    logic                resp_valid_q;
    logic [JOBS_W-1:0]   jobs_q;

    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_vld;
    logic                xfer;
    logic                wd_expire;
    logic [NUM_REQ-1:0]  req_ready;

    // Round-robin search starting at rr_ptr, first valid requester wins.
    always_comb begin
        cand      = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_vld && bus.req_valid_din[cand]) begin
                grant_idx = cand;
                grant_vld = 1'b1;
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    assign xfer      = (state_q == IDLE) && grant_vld && !reset;
    assign wd_expire = (cnt_q == CNT_W'(TIMEOUT - 1));

    // One-hot ready on the granted requester.
    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.done_strobe_din || wd_expire) begin
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (bus.resp_ready_din) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs; flags track the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            pt_q         <= '0;
            key_q        <= '0;
            id_q         <= '0;
            ct_q         <= '0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            jobs_q       <= '0;
        end else begin
            start_q      <= (state_d == ISSUE);
            busy_q       <= (state_d != IDLE);
            resp_valid_q <= (state_d == DELIVER);

            if (xfer) begin
                pt_q     <= bus.req_plaintext_din[32'(grant_idx)*BLK_W +: BLK_W];
                key_q    <= bus.req_key_din[32'(grant_idx)*BLK_W +: BLK_W];
                id_q     <= grant_idx;
                rr_ptr_q <= ID_W'((32'(grant_idx) + 1) % NUM_REQ);
            end

            case (state_q)
                ISSUE: begin
                    cnt_q <= '0;
                end
                WAIT: begin
                    // A done in the expiry cycle still delivers the result.
                    if (bus.done_strobe_din) begin
                        ct_q  <= bus.ciphertext_din;
                        err_q <= 1'b0;
                    end else if (wd_expire) begin
                        ct_q  <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DELIVER: begin
                    if (bus.resp_ready_din) begin
                        jobs_q <= jobs_q + JOBS_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready_dout       = req_ready;
    assign bus.start_strobe_dout    = start_q;
    assign bus.plaintext_dout       = pt_q;
    assign bus.key_dout             = key_q;
    assign bus.resp_valid_dout      = resp_valid_q;
    assign bus.resp_id_dout         = id_q;
    assign bus.resp_ciphertext_dout = ct_q;
    assign bus.resp_error_dout      = err_q;
    assign bus.busy_dout            = busy_q;
    assign bus.jobs_done_dout       = jobs_q;

endmodule

// File: tb/tb_des_engine_scheduler.sv
// Directed bench for des_engine_scheduler with a response scoreboard.
module tb_des_engine_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TMO     = 32;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     ct;
        logic            err;
    } resp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    des_engine_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    des_engine_scheduler #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    resp_t       sb[$];
    int          total     = 0;
    int          bad       = 0;
    int          exp_jobs  = 0;
    int          start_cnt = 0;
    logic [63:0] pt_tab [NUM_REQ];
    logic [63:0] key_tab[NUM_REQ];

    // Start pulses seen on the engine side.
    always @(posedge clk) begin
        if (bus.start_strobe_dout) begin
            start_cnt <= start_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_slots();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_plaintext_din[64*i +: 64] = pt_tab[i];
            bus.req_key_din[64*i +: 64]       = key_tab[i];
        end
    endtask

    task automatic do_reset(input logic [NUM_REQ-1:0] valid_during);
        reset               = 1'b1;
        bus.req_valid_din   = valid_during;
        bus.done_strobe_din = 1'b0;
        bus.resp_ready_din  = 1'b0;
        tick();
        tick();
        check("ready_in_reset", 64'(bus.req_ready_dout), 64'(0));
        reset    = 1'b0;
        exp_jobs = 0;
        sb.delete();
    endtask

    // One job from the grant cycle (cycle 0) to the cycle after acceptance.
    // done_cyc = 0 means the engine never answers.
    task automatic job(input logic [NUM_REQ-1:0] exp_grant, input int done_cyc,
                       input logic [63:0] ct, input logic [NUM_REQ-1:0] valid_after,
                       input int hold);
        int    id = 0;
        int    resp_cyc;
        int    starts0;
        logic  err;
        resp_t r;
        resp_t got;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_grant[i]) id = i;
        end
        err      = (done_cyc == 0) || (done_cyc > TMO + 1);
        resp_cyc = err ? TMO + 2 : done_cyc + 1;
        r.id     = ID_W'(id);
        r.ct     = err ? 64'h0 : ct;
        r.err    = err;
        sb.push_back(r);
        starts0  = start_cnt;

        #1;
        check("grant", 64'(bus.req_ready_dout), 64'(exp_grant));
        tick();
        bus.req_valid_din = valid_after;
        check("start_pulse", 64'(bus.start_strobe_dout), 64'(1));
        check("engine_pt", bus.plaintext_dout, pt_tab[id]);
        check("engine_key", bus.key_dout, key_tab[id]);
        check("busy_job", 64'(bus.busy_dout), 64'(1));

        for (int c = 1; c < resp_cyc; c++) begin
            if (c > 1) begin
                check("no_resp_yet", 64'(bus.resp_valid_dout), 64'(0));
                check("no_restart", 64'(bus.start_strobe_dout), 64'(0));
                check("ready_while_busy", 64'(bus.req_ready_dout), 64'(0));
            end
            bus.done_strobe_din = (c == done_cyc);
            bus.ciphertext_din  = (c == done_cyc) ? ct : 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
        end
        bus.done_strobe_din = 1'b0;
        check("resp_valid", 64'(bus.resp_valid_dout), 64'(1));

        // Back-pressure with a spurious done in the middle.
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(bus.resp_valid_dout), 64'(1));
            check("hold_id", 64'(bus.resp_id_dout), 64'(r.id));
            check("hold_ct", bus.resp_ciphertext_dout, r.ct);
            check("hold_err", 64'(bus.resp_error_dout), 64'(r.err));
            check("hold_ready", 64'(bus.req_ready_dout), 64'(0));
            check("hold_start", 64'(bus.start_strobe_dout), 64'(0));
            bus.done_strobe_din = (h == 2);
            bus.ciphertext_din  = 64'hFFFF_0000_FFFF_0000;
            tick();
        end
        bus.done_strobe_din = 1'b0;

        bus.resp_ready_din = 1'b1;
        total++;
        assert (sb.size() > 0)
        else begin
            bad++;
            $error("FAIL sb_underflow: observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("resp_id", 64'(bus.resp_id_dout), 64'(got.id));
            check("resp_ct", bus.resp_ciphertext_dout, got.ct);
            check("resp_err", 64'(bus.resp_error_dout), 64'(got.err));
        end
        tick();
        bus.resp_ready_din = 1'b0;
        exp_jobs++;
        check("jobs_done", 64'(bus.jobs_done_dout), 64'(exp_jobs));
        check("idle_busy", 64'(bus.busy_dout), 64'(0));
        check("idle_resp", 64'(bus.resp_valid_dout), 64'(0));
        check("one_start", 64'(start_cnt), 64'(starts0 + 1));
    endtask

    initial begin
        reset                 = 1'b1;
        bus.req_valid_din     = '0;
        bus.req_plaintext_din = '0;
        bus.req_key_din       = '0;
        bus.done_strobe_din   = 1'b0;
        bus.ciphertext_din    = '0;
        bus.resp_ready_din    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pt_tab[i]  = 64'h1111_0000_0000_0000 * 64'(i + 1) + 64'(i);
            key_tab[i] = 64'hA5A5_0000_0000_5A5A ^ 64'(i * 3 + 7);
        end
        pt_tab[2]  = 64'h0123_4567_89AB_CDEF;
        key_tab[2] = 64'h1334_5779_9BBC_DFF1;
        load_slots();

        // Reset values.
        do_reset('0);
        check("rst_start", 64'(bus.start_strobe_dout), 64'(0));
        check("rst_pt", bus.plaintext_dout, 64'h0);
        check("rst_key", bus.key_dout, 64'h0);
        check("rst_resp_valid", 64'(bus.resp_valid_dout), 64'(0));
        check("rst_resp_id", 64'(bus.resp_id_dout), 64'(0));
        check("rst_resp_ct", bus.resp_ciphertext_dout, 64'h0);
        check("rst_resp_err", 64'(bus.resp_error_dout), 64'(0));
        check("rst_busy", 64'(bus.busy_dout), 64'(0));
        check("rst_jobs", 64'(bus.jobs_done_dout), 64'(0));

        // Single request from requester 2, done 16 cycles after the start.
        bus.req_valid_din = 4'b0100;
        job(4'b0100, 17, 64'h85E8_1354_0F0A_B405, 4'b0000, 0);

        // Round-robin with all requesters continuously valid from reset.
        do_reset(4'b1111);
        job(4'b0001, 2, 64'hC0DE_0000_0000_0000, 4'b1111, 0);
        job(4'b0010, 3, 64'hC0DE_0000_0000_0001, 4'b1111, 0);
        job(4'b0100, 5, 64'hC0DE_0000_0000_0002, 4'b1111, 0);
        job(4'b1000, 9, 64'hC0DE_0000_0000_0003, 4'b1111, 0);
        job(4'b0001, 2, 64'hC0DE_0000_0000_0004, 4'b1111, 0);
        bus.req_valid_din = '0;

        // Watchdog: engine never answers; late done during delivery ignored.
        bus.req_valid_din = 4'b0001;
        job(4'b0001, 0, 64'h0, 4'b0000, 5);

        // Back-pressure with requester 1 held valid throughout.
        bus.req_valid_din = 4'b0010;
        job(4'b0010, 4, 64'h0F1E_2D3C_4B5A_6978, 4'b0010, 10);
        check("regrant_ready", 64'(bus.req_ready_dout), 64'(4'b0010));
        bus.req_valid_din = '0;
        #1;
        check("dropped_ready", 64'(bus.req_ready_dout), 64'(0));
        tick();
        check("dropped_busy", 64'(bus.busy_dout), 64'(0));
        check("dropped_start", 64'(bus.start_strobe_dout), 64'(0));

        // Reset asserted five cycles after the start pulse.
        bus.req_valid_din = 4'b0100;
        #1;
        check("mid_grant", 64'(bus.req_ready_dout), 64'(4'b0100));
        tick();
        bus.req_valid_din = '0;
        check("mid_start", 64'(bus.start_strobe_dout), 64'(1));
        for (int i = 0; i < 5; i++) tick();
        reset             = 1'b1;
        bus.req_valid_din = 4'b1111;
        tick();
        check("mid_rst_start", 64'(bus.start_strobe_dout), 64'(0));
        check("mid_rst_pt", bus.plaintext_dout, 64'h0);
        check("mid_rst_key", bus.key_dout, 64'h0);
        check("mid_rst_resp_valid", 64'(bus.resp_valid_dout), 64'(0));
        check("mid_rst_resp_id", 64'(bus.resp_id_dout), 64'(0));
        check("mid_rst_busy", 64'(bus.busy_dout), 64'(0));
        check("mid_rst_jobs", 64'(bus.jobs_done_dout), 64'(0));
        check("mid_rst_ready", 64'(bus.req_ready_dout), 64'(0));
        reset    = 1'b0;
        exp_jobs = 0;

        // Done collides with watchdog expiry: the result wins; grant from rr_ptr 0.
        job(4'b0001, TMO + 1, 64'h5555_AAAA_1234_5678, 4'b0000, 0);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
